// File: rtl/msg_scheduler.sv
// msg_scheduler -- SHA-256 style message schedule generator.
//
// Accepts one 512-bit block, then emits NUM_WORDS 32-bit schedule words
// W[0..NUM_WORDS-1] over a valid/ready stream, followed by a one-cycle done
// pulse. The sixteen live words are kept in a 16-entry circular buffer; each
// expanded word overwrites the slot holding W[t-16] as it is transferred.
//
// Ports:
//   clk          rising-edge clock
//   n_rst        synchronous active-high reset (name kept for compatibility)
//   block_in     512-bit block, word 0 in [511:480], word 15 in [31:0]
//   block_valid  block_in holds a complete block
//   block_ready  scheduler idle and able to capture a block
//   w_out        current schedule word W[t] (0 when not emitting)
//   w_idx        index t of w_out (0 when not emitting)
//   w_valid      w_out / w_idx valid
//   w_ready      consumer accepts w_out
//   abort        (only with MSG_SCHED_ABORT_EN) drop the block mid-emit
//   done         one-cycle pulse after the final word is accepted
//
// Build option: define MSG_SCHED_ABORT_EN to add the abort input.
module msg_scheduler #(
  parameter int NUM_WORDS = 64
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic [511:0] block_in,
  input  logic         block_valid,
  output logic         block_ready,
  output logic [31:0]  w_out,
  output logic [5:0]   w_idx,
  output logic         w_valid,
  input  logic         w_ready,
`ifdef MSG_SCHED_ABORT_EN
  input  logic         abort,
`endif
  output logic         done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state, state_next;
  logic [5:0]  t;
  logic [31:0] mem [16];
  logic [31:0] w_word;
  logic        capture;
  logic        xfer;
  logic        last;
  logic        abort_hit;

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  // Slot arithmetic wraps naturally in 4 bits: (t-15)&15 == (t+1)&15.
  logic [3:0] slot, slot_m2, slot_m7, slot_m15;

  always_comb begin
    slot     = t[3:0];
    slot_m2  = slot - 4'd2;
    slot_m7  = slot - 4'd7;
    slot_m15 = slot - 4'd15;
    if (t[5:4] == 2'b00) begin
      w_word = mem[slot];
    end else begin
      w_word = sig1(mem[slot_m2]) + mem[slot_m7] + sig0(mem[slot_m15]) + mem[slot];
    end
  end

`ifdef MSG_SCHED_ABORT_EN
  assign abort_hit = (state == EMIT) && abort;
`else
  assign abort_hit = 1'b0;
`endif

  assign capture = (state == IDLE) && block_valid;
  assign xfer    = (state == EMIT) && w_ready && !abort_hit;
  assign last    = (t == 6'(NUM_WORDS - 1));

  always_comb begin
    state_next  = state;
    block_ready = 1'b0;
    w_valid     = 1'b0;
    done        = 1'b0;
    w_out       = '0;
    w_idx       = '0;
    case (state)
      IDLE: begin
        block_ready = 1'b1;
        if (block_valid) state_next = EMIT;
      end
      EMIT: begin
        w_valid = 1'b1;
        w_out   = w_word;
        w_idx   = t;
        if (abort_hit) begin
          state_next = IDLE;
        end else if (xfer && last) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (n_rst) begin
      state <= IDLE;
      t     <= '0;
    end else begin
      state <= state_next;
      if (capture) begin
        t <= '0;
      end else if (xfer && !last) begin
        t <= t + 6'd1;
      end
    end
  end

  // Buffer is not reset; its contents are only observable during EMIT.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      if (capture) begin
        for (int unsigned i = 0; i < 16; i++) begin
          mem[i] <= block_in[511 - 32*i -: 32];
        end
      end else if (xfer && (t[5:4] != 2'b00)) begin
        mem[slot] <= w_word;
      end
    end
  end

endmodule

// File: tb/tb_msg_scheduler.sv
// Scoreboard bench for msg_scheduler: the driver pushes expected words per
// block, the negedge monitor pops and compares on every accepted transfer and
// also checks stall stability and the done pulse position.
module tb_msg_scheduler;

  localparam int NUM_WORDS = 64;

  logic         clk = 1'b0;
  logic         n_rst;
  logic [511:0] block_in;
  logic         block_valid;
  logic         block_ready;
  logic [31:0]  w_out;
  logic [5:0]   w_idx;
  logic         w_valid;
  logic         w_ready;
  logic         abort;
  logic         done;

  always #5 clk = ~clk;

  msg_scheduler #(.NUM_WORDS(NUM_WORDS)) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .block_in    (block_in),
    .block_valid (block_valid),
    .block_ready (block_ready),
    .w_out       (w_out),
    .w_idx       (w_idx),
    .w_valid     (w_valid),
    .w_ready     (w_ready),
`ifdef MSG_SCHED_ABORT_EN
    .abort       (abort),
`endif
    .done        (done)
  );

  typedef struct {
    logic [5:0]  idx;
    logic [31:0] w;
  } exp_t;

  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  logic [31:0] mw [64];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ss0(input logic [31:0] x);
    return ((x >> 7) | (x << 25)) ^ ((x >> 18) | (x << 14)) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ss1(input logic [31:0] x);
    return ((x >> 17) | (x << 15)) ^ ((x >> 19) | (x << 13)) ^ (x >> 10);
  endfunction

  task automatic model(input logic [511:0] blk);
    for (int i = 0; i < 16; i++) mw[i] = blk[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++)
      mw[i] = ss1(mw[i-2]) + mw[i-7] + ss0(mw[i-15]) + mw[i-16];
  endtask

  task automatic push_block(input logic [511:0] blk, input bit is_abc);
    exp_t e;
    model(blk);
    for (int i = 0; i < NUM_WORDS; i++) begin
      e.idx = 6'(i);
      e.w   = mw[i];
      if (is_abc) begin
        case (i)
          0:  e.w = 32'h61626380;
          15: e.w = 32'h00000018;
          16: e.w = 32'h61626380;
          17: e.w = 32'h000F0000;
          default: ;
        endcase
      end
      sb.push_back(e);
    end
  endtask

  function automatic logic [511:0] make_block(input logic [31:0] seed);
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[511 - 32*i -: 32] = seed ^ (32'(i) * 32'h9E3779B9);
    return b;
  endfunction

  // Called in the IDLE cycle (posedge+1); returns one cycle later in EMIT.
  task automatic start_block(input logic [511:0] blk);
    block_in    = blk;
    block_valid = 1'b1;
    @(posedge clk); #1;
    block_valid = 1'b0;
    check("latency_valid", 32'(w_valid), 32'd1);
    check("latency_idx", 32'(w_idx), 32'd0);
  endtask

  task automatic wait_idx(input int target);
    bit hit = 0;
    for (int k = 0; k < 300 && !hit; k++) begin
      @(posedge clk); #1;
      if (w_valid && w_idx == 6'(target)) hit = 1;
    end
    if (!hit) check("wait_idx_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_done();
    bit hit = 0;
    for (int k = 0; k < 300 && !hit; k++) begin
      @(posedge clk); #1;
      if (done) hit = 1;
    end
    if (!hit) check("wait_done_timeout", 32'd0, 32'd1);
    check("sb_empty_at_done", 32'(sb.size()), 32'd0);
    @(posedge clk); #1;
    check("done_one_cycle", 32'(done), 32'd0);
    check("idle_ready", 32'(block_ready), 32'd1);
  endtask

  // Monitor
  logic        prev_stall = 1'b0;
  logic [31:0] stall_w;
  logic [5:0]  stall_idx;
  logic        exp_done = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (n_rst) begin
      prev_stall = 1'b0;
      exp_done   = 1'b0;
    end else begin
      if (done || exp_done) check("done_pulse", 32'(done), 32'(exp_done));
      if (prev_stall && w_valid) begin
        check("stall_w_out", w_out, stall_w);
        check("stall_w_idx", 32'(w_idx), 32'(stall_idx));
      end
      if (w_valid && w_ready && !abort) begin
        if (sb.size() == 0) begin
          check("unexpected_word", 32'(w_idx), 32'hFFFFFFFF);
        end else begin
          e = sb.pop_front();
          check("w_idx", 32'(w_idx), 32'(e.idx));
          check("w_out", w_out, e.w);
        end
        exp_done = (w_idx == 6'(NUM_WORDS - 1));
      end else begin
        exp_done = 1'b0;
      end
      prev_stall = w_valid && !w_ready;
      stall_w    = w_out;
      stall_idx  = w_idx;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [511:0] abc_blk;
    int c0, c1;
    n_rst       = 1'b1;
    block_valid = 1'b0;
    block_in    = '0;
    w_ready     = 1'b1;
    abort       = 1'b0;
    repeat (2) @(posedge clk);
    #1 n_rst = 1'b0;
    check("rst_block_ready", 32'(block_ready), 32'd1);
    check("rst_w_valid", 32'(w_valid), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_w_idx", 32'(w_idx), 32'd0);
    check("rst_w_out", w_out, 32'd0);

    // Zero block: every word 0.
    push_block('0, 1'b0);
    start_block('0);
    wait_done();

    // "abc" padded block.
    abc_blk = '0;
    abc_blk[511:480] = 32'h61626380;
    abc_blk[31:0]    = 32'h00000018;
    push_block(abc_blk, 1'b1);
    start_block(abc_blk);
    wait_done();

    // Stall 5 cycles at t=20.
    push_block(make_block(32'h0123_4567), 1'b0);
    start_block(make_block(32'h0123_4567));
    wait_idx(20);
    w_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("stall_idx_held", 32'(w_idx), 32'd20);
    w_ready = 1'b1;
    wait_done();

    // Reset at t=30, then a fresh block from idx 0.
    push_block(make_block(32'hDEAD_BEEF), 1'b0);
    start_block(make_block(32'hDEAD_BEEF));
    wait_idx(30);
    n_rst = 1'b1;
    @(posedge clk); #1;
    n_rst = 1'b0;
    check("midrst_w_valid", 32'(w_valid), 32'd0);
    check("midrst_block_ready", 32'(block_ready), 32'd1);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_w_out", w_out, 32'd0);
    sb.delete();
    push_block(make_block(32'hCAFE_F00D), 1'b0);
    start_block(make_block(32'hCAFE_F00D));
    wait_done();

    // Back-to-back with block_valid held high; block_in changes mid-EMIT.
    push_block(make_block(32'h1111_2222), 1'b0);
    push_block(make_block(32'h3333_4444), 1'b0);
    block_in    = make_block(32'h1111_2222);
    block_valid = 1'b1;
    @(posedge clk); #1;
    check("b2b_first_valid", 32'(w_valid), 32'd1);
    c0 = cyc;
    block_in = make_block(32'h3333_4444);
    begin
      bit hit = 0;
      for (int k = 0; k < 300 && !hit; k++) begin
        @(posedge clk); #1;
        if (done) hit = 1;
      end
      if (!hit) check("b2b_done_timeout", 32'd0, 32'd1);
    end
    @(posedge clk); #1;
    check("b2b_idle_ready", 32'(block_ready), 32'd1);
    @(posedge clk); #1;
    check("b2b_second_valid", 32'(w_valid), 32'd1);
    check("b2b_second_idx", 32'(w_idx), 32'd0);
    c1 = cyc;
    check("b2b_period", 32'(c1 - c0), 32'(NUM_WORDS + 2));
    block_valid = 1'b0;
    wait_done();

`ifdef MSG_SCHED_ABORT_EN
    push_block(make_block(32'h5555_AAAA), 1'b0);
    start_block(make_block(32'h5555_AAAA));
    wait_idx(40);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_w_valid", 32'(w_valid), 32'd0);
    check("abort_block_ready", 32'(block_ready), 32'd1);
    check("abort_done", 32'(done), 32'd0);
    sb.delete();
    @(posedge clk); #1;
    check("abort_no_done_later", 32'(done), 32'd0);
`endif

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/msg_scheduler.md
MSG_SCHEDULER -- requirements
Module: msg_scheduler

Interface
REQ-001 Parameter NUM_WORDS, default 64, number of schedule words emitted per block (legal range 16..64).
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 n_rst  input  1  synchronous active-high reset, sampled on rising clk only.
REQ-004 block_in  input  512  message block from the byte-shift bridge; word 0 = block_in[511:480], word 15 = block_in[31:0].
REQ-005 block_valid  input  1  block_in holds a complete block.
REQ-006 block_ready  output  1  scheduler can accept a block.
REQ-007 w_out  output  32  current schedule word W[t].
REQ-008 w_idx  output  6  index t of w_out.
REQ-009 w_valid  output  1  w_out/w_idx valid.
REQ-010 w_ready  input  1  consumer accepts w_out.
REQ-011 done  output  1  one-cycle pulse after the final word is accepted.

Function
REQ-012 FSM states: IDLE, EMIT, DONE.
REQ-013 IDLE: block_ready=1, w_valid=0; block_valid=1 captures the 16 words into a 16x32 circular buffer, clears t to 0 and moves to EMIT on the same edge.
REQ-014 Block-accept latency: w_valid=1 with t=0 on the cycle after the capture edge.
REQ-015 EMIT: block_ready=0, w_valid=1; block_valid is ignored.
REQ-016 For t<16, w_out = buffer[t].
REQ-017 For t>=16, w_out = s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16], mod 2^32, read from slots (t-2)&15, (t-7)&15, (t-15)&15, t&15.
REQ-018 s0(x) = ROTR7 ^ ROTR18 ^ SHR3; s1(x) = ROTR17 ^ ROTR19 ^ SHR10.
REQ-019 Handshake: a word transfers on an edge with w_valid&w_ready; for t>=16 w_out is written into slot t&15 and t increments on that edge.
REQ-020 Stall: while w_valid=1 and w_ready=0, w_out, w_idx and buffer contents hold stable; no word is dropped or repeated.
REQ-021 Transfer of t=NUM_WORDS-1 moves to DONE; t does not wrap.
REQ-022 DONE: done=1, w_valid=0, block_ready=0 for exactly one cycle, then IDLE.
REQ-023 Back-to-back: the next block is accepted no earlier than the IDLE cycle after DONE; minimum block period is NUM_WORDS+2 cycles with w_ready held high.

Reset
REQ-024 n_rst=1 at any edge, including mid-EMIT or DONE, forces IDLE, t=0, w_valid=0, done=0, w_idx=0, w_out=0; block_ready=1 on the first cycle after reset is released.
REQ-025 Buffer contents need not be cleared by reset; w_out is forced to 0 outside EMIT.

Configuration
REQ-026 Macro MSG_SCHED_ABORT_EN defined: adds input abort (1 bit); abort=1 in EMIT returns to IDLE on that edge with no done pulse and no transfer, even if w_ready=1; abort is ignored in IDLE/DONE.
REQ-027 Macro undefined: no abort port; EMIT exits only through REQ-021 or reset.

Verification
REQ-028 Zero block: block_in=0, block_valid pulse, w_ready=1 -> 64 words all 0x00000000, w_idx 0..63 consecutive, done pulses one cycle after w_idx=63 transfers.
REQ-029 "abc" padded block (0x61626380, 14 zero words, 0x00000018) -> W[0]=0x61626380, W[15]=0x00000018, W[16]=0x61626380, W[17]=0x000F0000.
REQ-030 Stall: w_ready low for 5 cycles at t=20 -> w_out/w_idx unchanged throughout stall, W[20] emitted exactly once, remaining sequence identical to the unstalled run.
REQ-031 Reset mid-operation: n_rst high at t=30 -> next cycle IDLE, w_valid=0, block_ready=1, no done; a new block then restarts at w_idx=0.
REQ-032 Back-to-back blocks with block_valid held high -> second capture occurs on the IDLE cycle after DONE; block_valid is ignored throughout EMIT.
REQ-033 With MSG_SCHED_ABORT_EN: abort=1 at t=40 with w_ready=1 -> W[40] not transferred, no done pulse, block_ready=1 on the next cycle.
